// File: rtl/tdd_pkg.sv
// rtl/tdd_pkg.sv - shared types, defaults and helpers for the TDD frame scheduler
package tdd_pkg;
  localparam int CW_DEF = 24;
  localparam int FW_DEF = 16;

  typedef enum logic [2:0] {ST_IDLE, ST_RX, ST_GRT, ST_TX, ST_GTR} tdd_state_t;

  function automatic logic [31:0] pa_clamp(input logic [31:0] lead, input logic [31:0] gap);
    return (lead < gap) ? lead : gap;
  endfunction

  // Segment index within a frame: 0=RX, 1=GRT, 2=TX, 3=GTR
  function automatic tdd_state_t seg_state(input logic [1:0] idx);
    case (idx)
      2'd0:    return ST_RX;
      2'd1:    return ST_GRT;
      2'd2:    return ST_TX;
      default: return ST_GTR;
    endcase
  endfunction
endpackage

// File: rtl/tdd_sched_seg_cnt.sv
// rtl/tdd_sched_seg_cnt.sv - ce-qualified loadable down-counter with zero flag
module tdd_seg_cnt #(
  parameter int CW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          ce,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] count_nxt,
  output logic          zero
);
  logic [CW-1:0] count;

  // Next value is exported so registered decodes can look one cycle ahead
  always_comb begin
    count_nxt = count;
    if (load)
      count_nxt = load_val;
    else if (ce && count != '0)
      count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count <= '0;
    else     count <= count_nxt;
  end

  assign zero = (count == '0);
endmodule

// File: rtl/tdd_sched.sv
// rtl/tdd_sched.sv - TDD frame scheduler: RX/guard/TX/guard sequencing, stream gates and RF controls
module tdd_sched
  import tdd_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int FW = FW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          start,
  input  logic          ce,
  input  logic [CW-1:0] rx_len,
  input  logic [CW-1:0] gap_rt,
  input  logic [CW-1:0] tx_len,
  input  logic [CW-1:0] gap_tr,
  input  logic [CW-1:0] pa_lead,
  input  logic [FW-1:0] n_frames,
  output logic          rx_gate,
  output logic          tx_gate,
  output logic          tx_rx,
  output logic          pa_en,
  output logic          rf_sw,
  output logic          frame_start,
  output logic          busy,
  output logic [FW-1:0] frame_cnt,
  output logic          cfg_err
);
  tdd_state_t    state, state_n;
  logic [CW-1:0] in_len [4];
  logic [CW-1:0] sh_len [4];
  logic [CW-1:0] sh_lead, in_lead, lead_eff, load_val, cnt_nxt;
  logic [FW-1:0] cnt_inc;
  logic [1:0]    cur_idx, first_idx, nxt_idx;
  logic          nxt_found, cfg_zero, latch, load, fs_n, frame_done, err_set, run_clr, cnt_zero;

  assign in_len[0] = rx_len;
  assign in_len[1] = gap_rt;
  assign in_len[2] = tx_len;
  assign in_len[3] = gap_tr;
  assign in_lead   = CW'(pa_clamp(32'(pa_lead), 32'(gap_rt)));
  assign lead_eff  = latch ? in_lead : sh_lead;
  assign cfg_zero  = (rx_len == '0) && (tx_len == '0);
  assign cnt_inc   = (&frame_cnt) ? frame_cnt : frame_cnt + FW'(1);
  assign rf_sw     = tx_rx;

  tdd_seg_cnt #(.CW(CW)) u_seg_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .ce       (ce),
    .load_val (load_val),
    .count_nxt(cnt_nxt),
    .zero     (cnt_zero)
  );

  always_comb begin
    cur_idx = 2'd0;
    case (state)
      ST_GRT:  cur_idx = 2'd1;
      ST_TX:   cur_idx = 2'd2;
      ST_GTR:  cur_idx = 2'd3;
      default: cur_idx = 2'd0;
    endcase
  end

  // Zero-length segments are skipped by searching for the next non-zero one
  always_comb begin
    first_idx = 2'd3;
    for (int i = 3; i >= 0; i--)
      if (in_len[i] != '0) first_idx = 2'(i);
    nxt_found = 1'b0;
    nxt_idx   = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (i > int'(cur_idx) && sh_len[i] != '0) begin
        nxt_found = 1'b1;
        nxt_idx   = 2'(i);
      end
  end

  always_comb begin
    state_n    = state;
    latch      = 1'b0;
    load       = 1'b0;
    load_val   = '0;
    fs_n       = 1'b0;
    frame_done = 1'b0;
    err_set    = 1'b0;
    run_clr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && en) begin
          if (cfg_zero) begin
            err_set = 1'b1;
          end else begin
            latch    = 1'b1;
            run_clr  = 1'b1;
            fs_n     = 1'b1;
            load     = 1'b1;
            load_val = in_len[first_idx] - CW'(1);
            state_n  = seg_state(first_idx);
          end
        end
      end
      default: begin
        if (ce && cnt_zero) begin
          if (nxt_found) begin
            load     = 1'b1;
            load_val = sh_len[nxt_idx] - CW'(1);
            state_n  = seg_state(nxt_idx);
          end else begin
            frame_done = 1'b1;
            if (!en || cfg_zero || (n_frames != '0 && cnt_inc == n_frames)) begin
              state_n = ST_IDLE;
            end else begin
              latch    = 1'b1;
              fs_n     = 1'b1;
              load     = 1'b1;
              load_val = in_len[first_idx] - CW'(1);
              state_n  = seg_state(first_idx);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      for (int i = 0; i < 4; i++) sh_len[i] <= '0;
      sh_lead     <= '0;
      frame_cnt   <= '0;
      cfg_err     <= 1'b0;
      rx_gate     <= 1'b0;
      tx_gate     <= 1'b0;
      tx_rx       <= 1'b0;
      pa_en       <= 1'b0;
      busy        <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state <= state_n;
      if (latch) begin
        for (int i = 0; i < 4; i++) sh_len[i] <= in_len[i];
        sh_lead <= in_lead;
      end
      if (run_clr)         frame_cnt <= '0;
      else if (frame_done) frame_cnt <= cnt_inc;
      if (err_set) cfg_err <= 1'b1;
      // Outputs decode the next state so they line up with the state register
      rx_gate     <= (state_n == ST_RX);
      tx_gate     <= (state_n == ST_TX);
      tx_rx       <= (state_n == ST_GRT) || (state_n == ST_TX);
      pa_en       <= (state_n == ST_TX) || ((state_n == ST_GRT) && (cnt_nxt < lead_eff));
      busy        <= (state_n != ST_IDLE);
      frame_start <= fs_n;
    end
  end
endmodule

// File: tb/tb_tdd_sched.sv
// tb/tb_tdd_sched.sv - directed self-checking bench for tdd_sched
module tb_tdd_sched;
  localparam int CW = 24;
  localparam int FW = 16;

  logic          clk = 1'b0;
  logic          rst, en, start, ce;
  logic [CW-1:0] rx_len, gap_rt, tx_len, gap_tr, pa_lead;
  logic [FW-1:0] n_frames;
  logic          rx_gate, tx_gate, tx_rx, pa_en, rf_sw, frame_start, busy, cfg_err;
  logic [FW-1:0] frame_cnt;

  int checks = 0;
  int failures = 0;
  int n_rx, n_tx, n_txrx, n_pa, n_busy, n_fs, n_swbad;
  int first_rx, first_tx, first_txrx, first_pa, last_pa, last_tx;
  int fs_pos [4];

  tdd_sched #(.CW(CW), .FW(FW)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .ce(ce),
    .rx_len(rx_len), .gap_rt(gap_rt), .tx_len(tx_len), .gap_tr(gap_tr),
    .pa_lead(pa_lead), .n_frames(n_frames),
    .rx_gate(rx_gate), .tx_gate(tx_gate), .tx_rx(tx_rx), .pa_en(pa_en),
    .rf_sw(rf_sw), .frame_start(frame_start), .busy(busy),
    .frame_cnt(frame_cnt), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cfg(input int rl, input int grt, input int tl, input int gtr, input int pl, input int nf);
    rx_len = CW'(rl); gap_rt = CW'(grt); tx_len = CW'(tl); gap_tr = CW'(gtr);
    pa_lead = CW'(pl); n_frames = FW'(nf);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Samples cycle i (0 = cycle after the start edge), then drives ce for the next edge
  task automatic observe(input int n, input int ce_div, input int en_off);
    n_rx = 0; n_tx = 0; n_txrx = 0; n_pa = 0; n_busy = 0; n_fs = 0; n_swbad = 0;
    first_rx = -1; first_tx = -1; first_txrx = -1; first_pa = -1; last_pa = -1; last_tx = -1;
    for (int k = 0; k < 4; k++) fs_pos[k] = -1;
    for (int i = 0; i < n; i++) begin
      if (rx_gate) begin n_rx++; if (first_rx < 0) first_rx = i; end
      if (tx_gate) begin n_tx++; last_tx = i; if (first_tx < 0) first_tx = i; end
      if (tx_rx) begin n_txrx++; if (first_txrx < 0) first_txrx = i; end
      if (pa_en) begin n_pa++; last_pa = i; if (first_pa < 0) first_pa = i; end
      if (busy) n_busy++;
      if (rf_sw != tx_rx) n_swbad++;
      if (frame_start) begin if (n_fs < 4) fs_pos[n_fs] = i; n_fs++; end
      ce = ((i % ce_div) == ce_div - 1);
      if (i == en_off) en = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; start = 1'b0; ce = 1'b0;
    cfg(4, 2, 3, 1, 0, 2);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", int'({rx_gate, tx_gate, tx_rx, pa_en, rf_sw, frame_start, busy, cfg_err}), 0);
    check("reset_fcnt", int'(frame_cnt), 0);
    rst = 1'b0; en = 1'b1;
    @(posedge clk); #1;

    // Two 10-cycle frames, ce every cycle
    pulse_start();
    observe(25, 1, -1);
    check("t1_rx", n_rx, 8);
    check("t1_txrx", n_txrx, 10);
    check("t1_tx", n_tx, 6);
    check("t1_first_rx", first_rx, 0);
    check("t1_first_tx", first_tx, 6);
    check("t1_pa", n_pa, 6);
    check("t1_fs", n_fs, 2);
    check("t1_fs0", fs_pos[0], 0);
    check("t1_fs1", fs_pos[1], 10);
    check("t1_busy", n_busy, 20);
    check("t1_fcnt", int'(frame_cnt), 2);
    check("t1_rfsw", n_swbad, 0);

    // Same frames with ce every third cycle
    pulse_start();
    observe(65, 3, -1);
    check("t2_rx", n_rx, 24);
    check("t2_tx", n_tx, 18);
    check("t2_first_tx", first_tx, 18);
    check("t2_fs1", fs_pos[1], 30);
    check("t2_busy", n_busy, 60);
    check("t2_fcnt", int'(frame_cnt), 2);

    // pa_lead larger than gap_rt is clamped
    cfg(4, 2, 3, 1, 5, 1);
    pulse_start();
    observe(14, 1, -1);
    check("t3_pa_first", first_pa, 4);
    check("t3_txrx_first", first_txrx, 4);
    check("t3_pa_last", last_pa, 8);
    check("t3_tx_last", last_tx, 8);
    check("t3_pa_n", n_pa, 5);

    // pa_lead=1 leads tx_gate by one strobe
    cfg(4, 2, 3, 1, 1, 1);
    pulse_start();
    observe(14, 1, -1);
    check("t3b_pa_first", first_pa, 5);
    check("t3b_pa_n", n_pa, 4);

    // Both main segments zero: start rejected
    cfg(0, 2, 0, 1, 0, 1);
    pulse_start();
    observe(3, 1, -1);
    check("t4_busy", n_busy, 0);
    check("t4_err", int'(cfg_err), 1);

    // rx_len=0: frame begins in GRT
    cfg(0, 1, 3, 1, 0, 1);
    pulse_start();
    observe(8, 1, -1);
    check("t4b_rx", n_rx, 0);
    check("t4b_txrx_first", first_txrx, 0);
    check("t4b_tx_first", first_tx, 1);
    check("t4b_busy", n_busy, 5);
    check("t4b_fs", n_fs, 1);
    check("t4b_err_sticky", int'(cfg_err), 1);

    // Continuous mode, en dropped mid-TX: frame completes then idles
    cfg(4, 2, 3, 1, 0, 0);
    pulse_start();
    observe(16, 1, 7);
    check("t5_busy", n_busy, 10);
    check("t5_fs", n_fs, 1);
    check("t5_fcnt", int'(frame_cnt), 1);
    en = 1'b1;

    // Reset mid-TX, then a clean frame
    cfg(4, 2, 3, 1, 0, 1);
    pulse_start();
    observe(7, 1, -1);
    check("t6_in_tx", int'(tx_gate), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6_rst_outs", int'({rx_gate, tx_gate, tx_rx, pa_en, rf_sw, frame_start, busy, cfg_err}), 0);
    check("t6_rst_fcnt", int'(frame_cnt), 0);
    pulse_start();
    observe(12, 1, -1);
    check("t6_rx", n_rx, 4);
    check("t6_tx", n_tx, 3);
    check("t6_busy", n_busy, 10);
    check("t6_fcnt", int'(frame_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
